float_add_pipe: RTL and testbench
=================================

# float_add_pipe

Parametrised, pipelined IEEE-style floating-point adder/subtractor for the systolic matrix-multiply datapath. It is the accumulation stage behind each processing element's multiplier. It accepts signed operands of configurable exponent and mantissa width, supports an add/subtract mode, and handles subnormals. Results use round-to-nearest-even with saturation on overflow. A fixed three-stage pipeline with a valid/ready handshake lets it stall with the array.

## Interface
- `EXP_W`, default 3: exponent width. Bias is `2^(EXP_W-1)-1`.
- `MAN_W`, default 4: stored mantissa width. The hidden bit is implied.
- `W`, derived as `1+EXP_W+MAN_W` (8 by default): word width, laid out {sign, exp, man}.

Ports (clock and reset first):
- `clk`, in, 1: the single clock. Everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: the operand pair is present.
- `in_ready`, out, 1: the block accepts operands this cycle.
- `a`, in, W: operand A.
- `b`, in, W: operand B.
- `sub`, in, 1: 1 computes a−b (B's sign inverted), 0 computes a+b.
- `out_valid`, out, 1: `out` holds a result.
- `out_ready`, in, 1: the downstream block takes the result.
- `out`, out, W: the rounded sum.

## Operation
- Encoding: exp=0 is a subnormal. It has no hidden bit and an effective exponent of 1. There is no inf/NaN. All-ones exp is an ordinary finite value.
- S1, align:
  - Apply `sub` to B's sign.
  - Swap the operands so that |X| ≥ |Y|, comparing {exp, man}.
  - Right-shift Y's significand by the exponent difference into a MAN_W+4 bit field: hidden, man, guard, round, sticky. Any shifted-out 1 ORs into sticky.
  - A shift of MAN_W+3 or more leaves only sticky.
- S2, add: effective subtract is sign(X)≠sign(Y).
  - Add case: the significands sum into MAN_W+5 bits.
  - Subtract case: the result is X−Y, which is never negative.
  - The result sign is sign(X).
- S3, normalise and round:
  - On carry-out, shift right 1 (old LSB into sticky) and exp+1.
  - Otherwise, left-shift by the leading-zero count, limited so that exp does not go below 1. If the hidden bit is still 0 after that, the result is subnormal (exp field 0).
  - Round to nearest even on guard/round/sticky. A mantissa carry from rounding increments exp.
- Exact zero result (e.g. x−x): the output is +0 (all zeros).
- Overflow (exp exceeds all-ones after normalise or round): saturate to the max finite magnitude {sign, all-ones exp, all-ones man}.
- Combinational path: none from inputs to `out`. `in_ready` depends combinationally on `out_ready` and `out_valid` only.

## Timing
- Latency is exactly 3 cycles from acceptance (`in_valid && in_ready`) to `out_valid`. With no stall, throughput is 1 per cycle.
- Pipeline advance: `adv = !out_valid || out_ready`. `in_ready = adv`.
  - When `adv`=0 all stages hold, including any bubbles.
  - Stalling is global; there are no partial bubble-collapse requirements.
- `out` and `out_valid` stay stable while `out_valid && !out_ready`.
- Per-stage valid bits travel with the data. Bubbles (in_valid=0) produce no output.
- Reset (async, any time, including mid-operation): all stage valids and `out_valid` go to 0, and `out` goes to 0. In-flight operations are discarded. `in_ready` is 1 after reset.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

## Structure
- Package `float_pkg` holds:
  - the default `EXP_W`/`MAN_W`;
  - the bias function;
  - the field-extract helpers (sign/exp/man);
  - `MAX_FINITE` construction;
  - the GRS width constant shared with the multiplier.
- Sub-module `lzc` is a parametrised leading-zero counter over MAN_W+5 bits, used in S3.

## Test plan
Defaults are EXP_W=3, MAN_W=4. `out_ready`=1 unless stated.
- Basic add: 0x30+0x30 → 0x40 at cycle 3. 0x38+0x30 → 0x44.
- Subtract and cancellation:
  - 0x38 with sub=1 against b=0x30 → 0x20.
  - 0x30+0xB0 → 0x00 (+0).
  - 0xB8+0x30 → 0xA0.
- Rounding:
  - 0x30+0x01 → 0x30 (below half).
  - 0x30+0x02 → 0x30 (tie, even).
  - 0x30+0x03 → 0x31.
  - 0x31+0x02 → 0x32 (tie to even).
- Subnormal and saturation:
  - 0x01+0x01 → 0x02.
  - 0x0F+0x01 → 0x10.
  - 0x7F+0x7F → 0x7F.
  - 0xFF+0xFF → 0xFF.
- Backpressure:
  - Stream 6 random pairs back-to-back and hold `out_ready`=0 for 5 cycles mid-stream.
  - Required: `in_ready` drops, `out` stays stable, and all 6 results arrive in order, matching the reference model.
- Reset mid-operation: assert `rst` asynchronously with 3 ops in flight → `out_valid`=0 and `out`=0 immediately. After release, no stale result appears, and the next op returns after 3 cycles.

Source files
------------

// File: rtl/float_pkg.sv
// Shared floating-point format helpers for the systolic datapath.
// Field widths are runtime arguments so one package serves every EXP_W/MAN_W instance.
package float_pkg;

  localparam int EXP_W_DEF = 3;
  localparam int MAN_W_DEF = 4;
  localparam int GRS_W     = 3;  // guard, round, sticky

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic get_sign(input logic [63:0] w, input int exp_w, input int man_w);
    return w[exp_w+man_w];
  endfunction

  function automatic logic [63:0] get_exp(input logic [63:0] w, input int exp_w, input int man_w);
    return (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_man(input logic [63:0] w, input int man_w);
    return w & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic [63:0] max_finite(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | ((64'd1 << (exp_w + man_w)) - 64'd1);
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module lzc #(
  parameter  int WIDTH = 9,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = CW'(WIDTH);
    // Ascending scan: the highest set bit is assigned last and wins.
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/float_add_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise+round) with
// a global-stall valid/ready pipeline.
module float_add_pipe
  import float_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out
);

  localparam int F  = MAN_W + 1 + GRS_W;  // hidden, man, guard, round, sticky
  localparam int G  = F + 1;              // plus carry-out
  localparam int CW = $clog2(G + 1);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: order operands by magnitude and align Y to X.
  logic             sa, sb, swap, sx, sy;
  logic [EXP_W-1:0] ea, eb, ex, ey, ex_eff, ey_eff, diff;
  logic [MAN_W-1:0] ma, mb, mx, my;
  logic [F-1:0]     x_fld, y_fld, y_shift, y_lost, y_al;

  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment) so no latch is inferred.
  always_comb begin
    sa      = get_sign(64'(a), EXP_W, MAN_W);
    sb      = get_sign(64'(b), EXP_W, MAN_W) ^ sub;
    ea      = EXP_W'(get_exp(64'(a), EXP_W, MAN_W));
    eb      = EXP_W'(get_exp(64'(b), EXP_W, MAN_W));
    ma      = MAN_W'(get_man(64'(a), MAN_W));
    mb      = MAN_W'(get_man(64'(b), MAN_W));
    swap    = {eb, mb} > {ea, ma};
    sx      = swap ? sb : sa;
    sy      = swap ? sa : sb;
    ex      = swap ? eb : ea;
    ey      = swap ? ea : eb;
    mx      = swap ? mb : ma;
    my      = swap ? ma : mb;
    ex_eff  = (ex == '0) ? EXP_W'(1) : ex;
    ey_eff  = (ey == '0) ? EXP_W'(1) : ey;
    diff    = ex_eff - ey_eff;
    x_fld   = {ex != '0, mx, {GRS_W{1'b0}}};
    y_fld   = {ey != '0, my, {GRS_W{1'b0}}};
    y_shift = y_fld >> diff;
    y_lost  = y_fld & ~({F{1'b1}} << diff);
    y_al    = {y_shift[F-1:1], y_shift[0] | (|y_lost)};
  end

  logic             s1_valid, s1_sign, s1_sub;
  logic [EXP_W-1:0] s1_exp;
  logic [F-1:0]     s1_x, s1_y;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_exp   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sx;
      s1_sub   <= sx ^ sy;
      s1_exp   <= ex_eff;
      s1_x     <= x_fld;
      s1_y     <= y_al;
    end
  end

  // S2: magnitude add or subtract; X >= Y so the difference is never negative.
  logic             s2_valid, s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [G-1:0]     s2_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_sum   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_sum   <= s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
    end
  end

  // S3: normalise, round to nearest even, saturate.
  logic [CW-1:0]    lz;
  logic [F-1:0]     norm;
  logic [EXP_W:0]   exp_n, exp_r;
  logic [MAN_W+1:0] mant;
  logic [MAN_W-1:0] man_r;
  logic             inc;
  logic [W-1:0]     res;
  int               sh;

  lzc #(.WIDTH(G)) u_lzc (
    .value (s2_sum),
    .count (lz)
  );

  always_comb begin
    sh    = 0;
    norm  = '0;
    exp_n = '0;
    exp_r = '0;
    man_r = '0;
    res   = '0;
    if (s2_sum[F]) begin
      norm  = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
      exp_n = {1'b0, s2_exp} + (EXP_W+1)'(1);
    end else begin
      // Left shift stops at exponent 1; anything still unnormalised is subnormal.
      sh = int'(lz) - 1;
      if (sh > int'(s2_exp) - 1) sh = int'(s2_exp) - 1;
      norm  = s2_sum[F-1:0] << sh;
      exp_n = (EXP_W+1)'(int'(s2_exp) - sh);
    end
    inc  = norm[GRS_W-1] & (norm[GRS_W-2] | (|norm[GRS_W-3:0]) | norm[GRS_W]);
    mant = {1'b0, norm[F-1:GRS_W]} + (MAN_W+2)'(inc);
    if (mant[MAN_W+1]) begin
      exp_r = exp_n + (EXP_W+1)'(1);
      man_r = mant[MAN_W:1];
    end else begin
      exp_r = mant[MAN_W] ? exp_n : '0;
      man_r = mant[MAN_W-1:0];
    end
    if (s2_sum == '0)
      res = '0;
    else if (exp_r > EXP_MAX)
      res = W'(max_finite(s2_sign, EXP_W, MAN_W));
    else
      res = {s2_sign, exp_r[EXP_W-1:0], man_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) out <= res;
    end
  end

endmodule

// File: tb/tb_float_add_pipe.sv
// Self-checking bench for float_add_pipe at EXP_W=3, MAN_W=4: directed vector
// table, random stream under backpressure, and reset mid-operation.
module tb_float_add_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sub, out_valid, out_ready;
  logic [7:0] a, b, out;

  float_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         acc;
    string      name;
  } sb_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   no_stall = 1'b1;
  sb_t  sbq[$];
  vec_t tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exact reference: values as integers in units of the subnormal LSB.
  function automatic int to_int(input logic [7:0] x);
    int e, sig, v;
    e   = int'(x[6:4]);
    sig = (e != 0) ? 16 + int'(x[3:0]) : int'(x[3:0]);
    v   = sig << (((e == 0) ? 1 : e) - 1);
    return x[7] ? -v : v;
  endfunction

  function automatic logic [7:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic s);
    int   sum, m, p, e, sh, sig, rem, half;
    logic sgn;
    sum = to_int(x) + (s ? -to_int(y) : to_int(y));
    if (sum == 0) return 8'h00;
    sgn = (sum < 0);
    m   = sgn ? -sum : sum;
    if (m < 16) return {sgn, 3'b000, m[3:0]};
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    sh   = p - 4;
    e    = sh + 1;
    sig  = m >> sh;
    rem  = m - (sig << sh);
    half = (sh > 0) ? (1 << (sh - 1)) : 0;
    if (sh > 0 && (rem > half || (rem == half && sig[0]))) sig++;
    if (sig == 32) begin
      sig = 16;
      e++;
    end
    if (e > 7) return {sgn, 7'h7F};
    return {sgn, e[2:0], sig[3:0]};
  endfunction

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                      input logic [7:0] vexp, input string name);
    bit acc = 1'b0;
    a = va;
    b = vb;
    sub = vs;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) sbq.push_back('{vexp, cyc, name});
    else check({"accept_timeout_", name}, 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  // Output monitor: scoreboard compare, latency, and hold-stability under stall.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_out  = 8'h00;
  always @(negedge clk) begin
    if (prev_hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out), 32'(prev_out));
    end
    if (out_valid && out_ready && !rst) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 32'(out), 32'hFFFF_FFFF);
      end else begin
        sb_t it;
        it = sbq.pop_front();
        check({"result_", it.name}, 32'(out), 32'(it.exp));
        if (no_stall) check({"latency_", it.name}, 32'(cyc - it.acc), 32'd3);
      end
    end
    prev_hold = out_valid && !out_ready && !rst;
    prev_out  = out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h30, 8'h30, 1'b0, 8'h40};
    tbl[1]  = '{8'h38, 8'h30, 1'b0, 8'h44};
    tbl[2]  = '{8'h38, 8'h30, 1'b1, 8'h20};
    tbl[3]  = '{8'h30, 8'hB0, 1'b0, 8'h00};
    tbl[4]  = '{8'hB8, 8'h30, 1'b0, 8'hA0};
    tbl[5]  = '{8'h30, 8'h01, 1'b0, 8'h30};
    tbl[6]  = '{8'h30, 8'h02, 1'b0, 8'h30};
    tbl[7]  = '{8'h30, 8'h03, 1'b0, 8'h31};
    tbl[8]  = '{8'h31, 8'h02, 1'b0, 8'h32};
    tbl[9]  = '{8'h01, 8'h01, 1'b0, 8'h02};
    tbl[10] = '{8'h0F, 8'h01, 1'b0, 8'h10};
    tbl[11] = '{8'h7F, 8'h7F, 1'b0, 8'h7F};
    tbl[12] = '{8'hFF, 8'hFF, 1'b0, 8'hFF};

    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    sub = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, streamed back-to-back at full throughput.
    for (int i = 0; i < 13; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].exp, $sformatf("vec%0d", i));
    drain();

    // Random stream with a 5-cycle output stall once results start arriving.
    @(posedge clk);
    #1;
    no_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] ra, rb;
          logic       rs;
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rs, ref_add(ra, rb, rs), $sformatf("rand%0d", i));
        end
      end
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          seen = out_valid;
        end
        check("stall_first_output", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    no_stall = 1'b1;

    // Reset with three operations in flight.
    @(posedge clk);
    #1;
    send(8'h30, 8'h30, 1'b0, 8'h40, "inflight0");
    send(8'h38, 8'h30, 1'b0, 8'h44, "inflight1");
    send(8'h01, 8'h01, 1'b0, 8'h02, "inflight2");
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h30, 8'h03, 1'b0, 8'h31, "post_reset");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
